// File: rtl/traffic_input_conditioner.sv
// Input conditioning ahead of the traffic-light controller: two-flop
// synchronisers, per-input debounce, minimum-green hold on ta/tb and
// single-cycle parade/release pulses.
module traffic_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_GREEN       = 5,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sa_raw,
    input  logic       sb_raw,
    input  logic       p_raw,
    input  logic       r_raw,
    input  logic [1:0] la,
    input  logic [1:0] lb,
    output logic       ta,
    output logic       tb,
    output logic       p,
    output logic       r
);

    localparam logic [1:0]       GREEN     = 2'b00;
    localparam logic [1:0]       RED       = 2'b10;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = (MIN_GREEN == 0) ? '0 : CNT_W'(MIN_GREEN - 1);
    localparam bit               HOLD_EN   = (MIN_GREEN != 0);

    // Channel order: 0 = sa, 1 = sb, 2 = p, 3 = r
    logic [3:0] raw;
    logic [3:0] deb_now;
    logic [3:0] deb_upd;
    logic [3:0] rise;

    assign raw  = {r_raw, p_raw, sb_raw, sa_raw};
    assign rise = deb_upd & ~deb_now;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic             s1;
        logic             s2;
        logic             deb;
        logic             deb_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;

        // Debounce: flip after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_comb begin
            deb_nx = deb;
            cnt_nx = '0;
            if (s2 != deb) begin
                if (cnt == DEB_LAST) begin
                    deb_nx = ~deb;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
        end

        // Synchroniser flops, debounced level and its counter
        always_ff @(posedge clk) begin
            if (!reset) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                deb <= 1'b0;
                cnt <= '0;
            end else begin
                s1  <= raw[g];
                s2  <= s1;
                deb <= deb_nx;
                cnt <= cnt_nx;
            end
        end

        assign deb_now[g] = deb;
        assign deb_upd[g] = deb_nx;
    end

    logic p_reg;
    logic r_reg;

    // Pulse on the debounced rising edge; release wins over parade when simultaneous
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_reg <= 1'b0;
            r_reg <= 1'b0;
        end else begin
            p_reg <= rise[2] & ~rise[3];
            r_reg <= rise[3];
        end
    end

    logic [1:0]       la_prev;
    logic [1:0]       lb_prev;
    logic [CNT_W-1:0] hold_a;
    logic [CNT_W-1:0] hold_b;
    logic [CNT_W-1:0] hold_a_nx;
    logic [CNT_W-1:0] hold_b_nx;
    logic             green_start_a;
    logic             green_start_b;
    logic             hold_active_a;
    logic             hold_active_b;

    // Green-start detection and minimum-green hold counters
    always_comb begin
        green_start_a = (la == GREEN) && (la_prev != GREEN);
        green_start_b = (lb == GREEN) && (lb_prev != GREEN);

        hold_a_nx = hold_a;
        if (green_start_a)       hold_a_nx = HOLD_LOAD;
        else if (la != GREEN)    hold_a_nx = '0;
        else if (hold_a != '0)   hold_a_nx = hold_a - CNT_W'(1);

        hold_b_nx = hold_b;
        if (green_start_b)       hold_b_nx = HOLD_LOAD;
        else if (lb != GREEN)    hold_b_nx = '0;
        else if (hold_b != '0)   hold_b_nx = hold_b - CNT_W'(1);

        hold_active_a = HOLD_EN && (green_start_a || (hold_a != '0));
        hold_active_b = HOLD_EN && (green_start_b || (hold_b != '0));
    end

    // Light history (reset to red so a green controller gets an initial hold)
    always_ff @(posedge clk) begin
        if (!reset) begin
            la_prev <= RED;
            lb_prev <= RED;
            hold_a  <= '0;
            hold_b  <= '0;
        end else begin
            la_prev <= la;
            lb_prev <= lb;
            hold_a  <= hold_a_nx;
            hold_b  <= hold_b_nx;
        end
    end

    assign ta = deb_now[0] | hold_active_a;
    assign tb = deb_now[1] | hold_active_b;
    assign p  = p_reg;
    assign r  = r_reg;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner: table of per-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_traffic_input_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sa_raw = 1'b0;
    logic       sb_raw = 1'b0;
    logic       p_raw = 1'b0;
    logic       r_raw = 1'b0;
    logic [1:0] la = 2'b00;
    logic [1:0] lb = 2'b10;
    logic       ta;
    logic       tb;
    logic       p;
    logic       r;

    int unsigned passed = 0;
    int unsigned total  = 0;

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .MIN_GREEN(5),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sa_raw(sa_raw),
        .sb_raw(sb_raw),
        .p_raw(p_raw),
        .r_raw(r_raw),
        .la(la),
        .lb(lb),
        .ta(ta),
        .tb(tb),
        .p(p),
        .r(r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sa;
        logic       sb;
        logic       pr;
        logic       rr;
        logic [1:0] la;
        logic [1:0] lb;
        logic       eta;
        logic       etb;
        logic       ep;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic sa, input logic [1:0] l_a,
                                input logic eta);
        vec_t v;
        v.rst = rst; v.sa = sa; v.sb = 1'b0; v.pr = 1'b0; v.rr = 1'b0;
        v.la = l_a; v.lb = 2'b10;
        v.eta = eta; v.etb = 1'b0; v.ep = 1'b0; v.er = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic sa, input logic sb, input logic pp,
                         input logic rr, input logic [1:0] l_a, input logic [1:0] l_b);
        reset = rst; sa_raw = sa; sb_raw = sb; p_raw = pp; r_raw = rr; la = l_a; lb = l_b;
    endtask

    task automatic expect4(input string tag, input logic eta, input logic etb,
                           input logic ep, input logic er);
        @(negedge clk);
        chk({tag, " ta"}, ta, eta);
        chk({tag, " tb"}, tb, etb);
        chk({tag, " p"}, p, ep);
        chk({tag, " r"}, r, er);
    endtask

    initial begin
        // Initial min-green after reset release, then sa debounce and glitch rejection
        for (int i = 0; i < 5; i++)   add(1'b1, 1'b0, 2'b00, 1'b1);
        for (int i = 5; i < 7; i++)   add(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 7; i < 13; i++)  add(1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 13; i < 15; i++) add(1'b1, 1'b1, 2'b00, 1'b1);
        for (int i = 15; i < 21; i++) add(1'b1, 1'b0, 2'b00, 1'b1);
        add(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 22; i < 25; i++) add(1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 25; i < 30; i++) add(1'b1, 1'b0, 2'b00, 1'b0);

        // Hold reset with the controller already green
        repeat (3) step();

        foreach (vecs[i]) begin
            step();
            drive(vecs[i].rst, vecs[i].sa, vecs[i].sb, vecs[i].pr, vecs[i].rr,
                  vecs[i].la, vecs[i].lb);
            expect4($sformatf("row%0d", i), vecs[i].eta, vecs[i].etb, vecs[i].ep, vecs[i].er);
        end

        // Parade button held: one pulse six edges after the press
        for (int i = 0; i < 20; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
            expect4($sformatf("press1 c%0d", i), 1'b0, 1'b0, (i == 6), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
            expect4($sformatf("release1 c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
            expect4($sformatf("press2 c%0d", i), 1'b0, 1'b0, (i == 6), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
            expect4($sformatf("release2 c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Simultaneous parade and release: only r pulses
        for (int i = 0; i < 10; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10);
            expect4($sformatf("both c%0d", i), 1'b0, 1'b0, 1'b0, (i == 6));
        end
        for (int i = 0; i < 10; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
            expect4($sformatf("both_rel c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // B-side green start: tb held for exactly five cycles
        for (int i = 0; i < 7; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
            expect4($sformatf("holdb c%0d", i), 1'b0, (i < 5), 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
            expect4($sformatf("redb c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Yellow during the hold clears it on the next edge
        for (int i = 0; i < 5; i++) begin
            step(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, (i < 2) ? 2'b00 : 2'b01);
            expect4($sformatf("abortb c%0d", i), 1'b0, (i <= 2), 1'b0, 1'b0);
        end

        // Reset during an A-side hold and sa/p debounce counts; B green re-detected
        for (int t = 0; t < 13; t++) begin
            step();
            drive((t == 4) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                  (t < 2 || t >= 5) ? 2'b10 : 2'b00, 2'b00);
            expect4($sformatf("midreset t%0d", t),
                    ((t >= 2 && t <= 4) || t >= 11), (t <= 9), (t == 11), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
